// File: rtl/fir_mac_engine.sv
// Signed MAC engine: TAPS pairs in, one dot product out; multiply then accumulate pipeline.
// Optional FIR_MAC_SAT_EN clamps y to the signed OUT_W range and raises ovf; otherwise y is truncated.
module fir_mac_engine #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAPS    = 8,
  parameter int GUARD_W = 7,
  parameter int OUT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [COEF_W-1:0] coef_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y,
  output logic              ovf
);

  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + GUARD_W;
  localparam int CNT_W = (TAPS > 2) ? $clog2(TAPS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic             p_vld_q, p_vld_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       state_q, state_d;
  logic             accept, last_tap;
  logic [PW-1:0]    xs, cs;

  assign in_ready = !out_valid_q && !(p_vld_q && p_last_q);
  assign accept   = in_valid && in_ready;
  assign last_tap = (cnt_q == CNT_W'(TAPS - 1));
  // Sign-extend both operands to the product width so the low PW bits give the signed product.
  assign xs = {{COEF_W{x_in[DATA_W-1]}}, x_in};
  assign cs = {{DATA_W{coef_in[COEF_W-1]}}, coef_in};

`ifdef FIR_MAC_SAT_EN
  logic ovf_q, ovf_d;
  logic fits;
  assign fits = (&acc_d[ACC_W-1:OUT_W-1]) || !(|acc_d[ACC_W-1:OUT_W-1]);
  assign ovf  = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    p_d         = p_q;
    p_vld_d     = accept;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
`ifdef FIR_MAC_SAT_EN
    ovf_d       = ovf_q;
`endif
    if (accept) begin
      cnt_d     = last_tap ? '0 : cnt_q + 1'b1;
      p_d       = xs * cs;
      p_first_d = (cnt_q == '0);
      p_last_d  = last_tap;
    end
    if (p_vld_q) begin
      acc_d = (p_first_q ? '0 : acc_q) + {{GUARD_W{p_q[PW-1]}}, p_q};
    end
    if (p_vld_q && p_last_q) begin
      out_valid_d = 1'b1;
`ifdef FIR_MAC_SAT_EN
      ovf_d = !fits;
      y_d   = fits ? acc_d[OUT_W-1:0] : {acc_d[ACC_W-1], {(OUT_W-1){!acc_d[ACC_W-1]}}};
`else
      y_d   = acc_d[OUT_W-1:0];
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCUM;
      ACCUM:   if (accept && last_tap) state_d = FLUSH;
      FLUSH:   if (p_vld_q && p_last_q) state_d = HOLD;
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
`ifdef FIR_MAC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      p_vld_q     <= p_vld_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
`ifdef FIR_MAC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with TAPS=4; expected values are hand-computed constants.
module tb_fir_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] coef_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  fir_mac_engine #(
    .DATA_W(16), .COEF_W(16), .TAPS(4), .GUARD_W(7), .OUT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .coef_in(coef_in),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns 1 ns after the edge that accepted it, then idles gap cycles.
  task automatic send(input logic [15:0] xv, input logic [15:0] cv, input int gap);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    x_in     = xv;
    coef_in  = cv;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) chk("send_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("take_out_valid_clear", {31'd0, out_valid}, 32'd0);
    chk("take_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_y", y, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: 1+2+3+4 back-to-back
    send(16'd1, 16'd1, 0);
    send(16'd2, 16'd1, 0);
    send(16'd3, 16'd1, 0);
    send(16'd4, 16'd1, 0);
    chk("t1_in_ready_after_last", {31'd0, in_ready}, 32'd0);
    chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_y", y, 32'd10);
    take();

    // 2: (-3)*5 four times
    for (int i = 0; i < 4; i++) send(16'hFFFD, 16'd5, 0);
    step();
    chk("t2_y", y, 32'hFFFF_FFC4);
    chk("t2_ovf", {31'd0, ovf}, 32'd0);
    take();

    // 3: result held under backpressure
    for (int i = 0; i < 4; i++) send(16'd1, 16'd1, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_y", y, 32'd4);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    take();
    send(16'd2, 16'd3, 0);
    chk("t3_next_frame_accepted", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) send(16'd2, 16'd3, 0);
    step();
    chk("t3_next_y", y, 32'd24);
    take();

    // 4: largest positive products overflow the 32-bit signed range
    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h7FFF, 0);
    step();
`ifdef FIR_MAC_SAT_EN
    chk("t4_y_sat", y, 32'h7FFF_FFFF);
    chk("t4_ovf_sat", {31'd0, ovf}, 32'd1);
`else
    chk("t4_y_trunc", y, 32'hFFFC_0004);
    chk("t4_ovf", {31'd0, ovf}, 32'd0);
`endif
    take();

    // 5: reset mid-frame
    send(16'd9, 16'd9, 0);
    send(16'd9, 16'd9, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_y", y, 32'd0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) send(16'd1, 16'd1, 0);
    step();
    chk("t5_y_no_residue", y, 32'd4);
    take();

    // 6: 3-cycle bubbles between taps
    for (int i = 0; i < 3; i++) send(16'd1, 16'd1, 3);
    send(16'd1, 16'd1, 0);
    chk("t6_not_yet_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t6_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_y", y, 32'd4);
    take();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
Parametrised signed multiply-accumulate engine for the FIR datapath. It accepts one sample/coefficient pair per cycle over a valid/ready handshake. After TAPS pairs it emits the accumulated dot product on a valid/ready output and clears itself for the next frame. It uses a two-stage pipeline (multiply, then accumulate) with wide guard bits and an optional saturating output narrowing. It sits between the sample delay line / coefficient ROM and the filter output register.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 8, pairs per output frame (>=2)
GUARD_W, 7, accumulator guard bits; ACC_W = DATA_W+COEF_W+GUARD_W (default 39)
OUT_W, 32, output width (<= ACC_W)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  pair on x_in/coef_in is valid
in_ready  output  1  engine can accept a pair this cycle
x_in  input  DATA_W  signed sample
coef_in  input  COEF_W  signed coefficient
out_valid  output  1  y holds a completed frame result
out_ready  input  1  downstream accepts y
y  output  OUT_W  signed result
ovf  output  1  result was clamped (saturation build only; else constant 0)

Behaviour:
- Reset: rst high clears all state asynchronously. y=0, out_valid=0, ovf=0, tap counter=0, accumulator=0, stage-1 valid=0, state=IDLE. Reset mid-frame discards the partial frame.
- Accept: a pair is accepted on a rising edge when in_valid && in_ready.
- in_ready is combinational: in_ready = !out_valid && !(stage-1 valid && stage-1 last).
- Stage 1 (multiply): on accept, p_q <= signed x_in*coef_in (DATA_W+COEF_W bits). p_vld <= 1, p_first <= (cnt==0), p_last <= (cnt==TAPS-1). With no accept, p_vld <= 0.
- Tap counter: increments on each accept and wraps to 0 after TAPS-1.
- Stage 2 (accumulate): when p_vld, acc <= (p_first ? 0 : acc) + sign-extended p_q. The accumulator wraps modulo 2^ACC_W with no flag.
- Result: when p_vld && p_last, the final sum is loaded into y (width rule below) and out_valid <= 1.
- Latency: out_valid rises on the 2nd rising edge after the TAPS-th accept.
- Width rule (non-saturating build): y = low OUT_W bits of the sum.
- Output handshake: y and out_valid hold until out_valid && out_ready, then out_valid clears on that edge. y keeps its last value.
- Throughput: minimum TAPS+2 cycles per frame, because in_ready is low from the last accept until the result is taken.
- Gaps: in_valid bubbles between taps are allowed and do not change the result.
- States: IDLE (cnt=0, no frame in flight) -> ACCUM on first accept. ACCUM -> FLUSH on TAPS-th accept. FLUSH -> HOLD when out_valid rises. HOLD -> IDLE on out_ready.
- Simultaneous events: out_ready in the same cycle out_valid rises is not possible, because out_valid is registered. An accept can occur in the cycle after the handshake.

Optional Feature:
FIR_MAC_SAT_EN
- Defined: y is the full ACC_W sum clamped to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1]. ovf is registered with y and is 1 when clamping occurred, else 0.
- Not defined: y is truncated as above and ovf is tied to 0.
- The accumulator itself never saturates in either build.

Test Plan:
1. TAPS=4, x=1,2,3,4, coef=1 each, back-to-back -> out_valid 2 cycles after 4th accept, y=10, then in_ready high after handshake.
2. x=0xFFFD (-3), coef=5, four taps -> y=0xFFFFFFC4 (-60), ovf=0.
3. Frame of 1*1 x4 with out_ready=0 for 5 cycles -> y=4 held stable, in_ready=0 throughout; release -> out_valid drops next edge, next frame accepted.
4. x=0x7FFF, coef=0x7FFF, four taps (sum 0xFFFC0004) -> with FIR_MAC_SAT_EN y=0x7FFFFFFF, ovf=1; without y=0xFFFC0004, ovf=0.
5. rst asserted after 2 of 4 taps -> y=0, out_valid=0 immediately; new frame of 1*1 x4 -> y=4 (no residue).
6. 1*1 x4 with 3-cycle in_valid gaps between taps -> y=4, out_valid 2 cycles after last accept.
